// File: rtl/decoder24_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : decoder24_scan_ctrl
//  Purpose  : Scan sequencer that drives a 2-to-4 decoder with active-high
//             enable. It walks the select code w through the slots enabled in
//             mask. Each slot is held for DIV active cycles with e=1, followed
//             by BLANK_CYCLES cycles with e=0. During the gap w moves to the
//             next slot, so the decoder never glitches between outputs.
//  Ports    : clk        - system clock, rising edge
//             rst        - asynchronous, active-high reset
//             run        - level; 1 = scan, 0 = stop (returns to IDLE)
//             mask[3:0]  - slot enable, bit i = slot i is scanned
//             hold       - (SCAN_HOLD_EN only) freezes counters and w
//             w[1:0]     - registered select code to the decoder
//             e          - registered enable to the decoder
//             slot_done  - pulse on the final active cycle of every slot
//             frame_done - pulse on the final active cycle of the last
//                          enabled slot of a frame
//  Params   : DIV          - active cycles per slot (>= 1)
//             BLANK_CYCLES - e=0 cycles between slots (>= 0)
//  Options  : define SCAN_HOLD_EN to add the hold input
//  Revision : 1.0 - initial release
// ============================================================================
module decoder24_scan_ctrl #(
  parameter int DIV          = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] mask,
`ifdef SCAN_HOLD_EN
  input  logic       hold,
`endif
  output logic [1:0] w,
  output logic       e,
  output logic       slot_done,
  output logic       frame_done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  localparam logic [DW-1:0] DWELL_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? BW'(BLANK_CYCLES - 1) : '0;
  localparam logic          HAS_BLANK  = (BLANK_CYCLES > 0);
  // With a one-cycle dwell every cycle that enters ACTIVE is also the final
  // cycle of its slot, so the pulse must be raised on entry.
  localparam logic          DIV_IS_ONE = (DIV == 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_BLANK  = 2'd2
  } state_t;

  state_t          state_q;
  logic [1:0]      w_q;
  logic            e_q;
  logic            slot_done_q;
  logic            frame_done_q;
  logic [DW-1:0]   dwell_q;
  logic [BW-1:0]   blank_q;
  // Set when the final dwell cycle was frozen by hold; the pulse is replayed
  // on the cycle hold is released instead of ending the slot silently.
  logic            held_q;

  logic            hold_act;
  logic [1:0]      first_slot;
  logic [1:0]      after_slot;
  logic [DW-1:0]   dwell_inc;
  logic [BW-1:0]   blank_inc;
  logic            dwell_last;
  logic            blank_last;

`ifdef SCAN_HOLD_EN
  assign hold_act = hold;
`else
  assign hold_act = 1'b0;
`endif

  // Lowest set bit above k, else lowest set bit overall (wrap-around).
  // Loops run downward so the last hit is the lowest index.
  function automatic logic [1:0] next_slot(input logic [1:0] k, input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      if (m[j]) r = 2'(j);
    end
    for (int j = 3; j >= 0; j--) begin
      if (m[j] && (j > int'(k))) r = 2'(j);
    end
    return r;
  endfunction

  // A slot closes the frame when the following choice does not move upward.
  function automatic logic wraps(input logic [1:0] k, input logic [3:0] m);
    return (m != 4'b0000) && (next_slot(k, m) <= k);
  endfunction

  // next(3) has no candidate above 3, so it yields the lowest set bit.
  assign first_slot = next_slot(2'd3, mask);
  assign after_slot = next_slot(w_q, mask);
  assign dwell_inc  = dwell_q + DW'(1);
  assign blank_inc  = blank_q + BW'(1);
  assign dwell_last = (dwell_q == DWELL_LAST);
  assign blank_last = (blank_q == BLANK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      w_q          <= 2'd0;
      e_q          <= 1'b0;
      slot_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      dwell_q      <= '0;
      blank_q      <= '0;
      held_q       <= 1'b0;
    end else begin
      // Pulses are single-cycle unless re-raised below.
      slot_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          w_q     <= 2'd0;
          e_q     <= 1'b0;
          dwell_q <= '0;
          blank_q <= '0;
          held_q  <= 1'b0;
          if (run && (mask != 4'b0000)) begin
            state_q <= S_ACTIVE;
            w_q     <= first_slot;
            e_q     <= 1'b1;
            if (DIV_IS_ONE) begin
              slot_done_q  <= 1'b1;
              frame_done_q <= wraps(first_slot, mask);
            end
          end
        end

        S_ACTIVE: begin
          if (!run) begin
            state_q <= S_IDLE;
            w_q     <= 2'd0;
            e_q     <= 1'b0;
            dwell_q <= '0;
            blank_q <= '0;
            held_q  <= 1'b0;
          end else if (hold_act) begin
            held_q <= dwell_last;
          end else if (!dwell_last) begin
            dwell_q <= dwell_inc;
            // Raise the pulse for the cycle whose dwell value is the last one.
            if (dwell_inc == DWELL_LAST) begin
              slot_done_q  <= 1'b1;
              frame_done_q <= wraps(w_q, mask);
            end
          end else if (held_q) begin
            held_q       <= 1'b0;
            slot_done_q  <= 1'b1;
            frame_done_q <= wraps(w_q, mask);
          end else if (mask == 4'b0000) begin
            state_q <= S_IDLE;
            w_q     <= 2'd0;
            e_q     <= 1'b0;
            dwell_q <= '0;
            blank_q <= '0;
          end else if (HAS_BLANK) begin
            state_q <= S_BLANK;
            w_q     <= after_slot;
            e_q     <= 1'b0;
            blank_q <= '0;
            dwell_q <= '0;
          end else begin
            // Zero blanking: e stays high while w steps straight to the next slot.
            w_q     <= after_slot;
            dwell_q <= '0;
            if (DIV_IS_ONE) begin
              slot_done_q  <= 1'b1;
              frame_done_q <= wraps(after_slot, mask);
            end
          end
        end

        S_BLANK: begin
          if (!run) begin
            state_q <= S_IDLE;
            w_q     <= 2'd0;
            e_q     <= 1'b0;
            dwell_q <= '0;
            blank_q <= '0;
            held_q  <= 1'b0;
          end else if (hold_act) begin
            held_q <= 1'b0;
          end else if (!blank_last) begin
            blank_q <= blank_inc;
          end else begin
            state_q <= S_ACTIVE;
            e_q     <= 1'b1;
            dwell_q <= '0;
            if (DIV_IS_ONE) begin
              slot_done_q  <= 1'b1;
              frame_done_q <= wraps(w_q, mask);
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          w_q     <= 2'd0;
          e_q     <= 1'b0;
          dwell_q <= '0;
          blank_q <= '0;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign w          = w_q;
  assign e          = e_q;
  assign slot_done  = slot_done_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder24_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder24_scan_ctrl
//  Purpose  : Self-checking bench for decoder24_scan_ctrl. Three instances
//             with different DIV / BLANK_CYCLES share run and mask. Each
//             instance is compared cycle by cycle with a slot-arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decoder24_scan_ctrl;

  localparam int NDUT = 3;
  localparam int DIVS [NDUT] = '{4, 2, 1};
  localparam int BLNK [NDUT] = '{1, 0, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [3:0] mask;
  logic       hold;

  logic [1:0] w_a, w_b, w_c;
  logic       e_a, e_b, e_c;
  logic       sd_a, sd_b, sd_c;
  logic       fd_a, fd_b, fd_c;

  logic [4:0] obs [NDUT];
  assign obs[0] = {e_a, w_a, sd_a, fd_a};
  assign obs[1] = {e_b, w_b, sd_b, fd_b};
  assign obs[2] = {e_c, w_c, sd_c, fd_c};

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decoder24_scan_ctrl #(.DIV(4), .BLANK_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .run(run), .mask(mask),
`ifdef SCAN_HOLD_EN
    .hold(hold),
`endif
    .w(w_a), .e(e_a), .slot_done(sd_a), .frame_done(fd_a));

  decoder24_scan_ctrl #(.DIV(2), .BLANK_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .run(run), .mask(mask),
`ifdef SCAN_HOLD_EN
    .hold(hold),
`endif
    .w(w_b), .e(e_b), .slot_done(sd_b), .frame_done(fd_b));

  decoder24_scan_ctrl #(.DIV(1), .BLANK_CYCLES(2)) u_c (
    .clk(clk), .rst(rst), .run(run), .mask(mask),
`ifdef SCAN_HOLD_EN
    .hold(hold),
`endif
    .w(w_c), .e(e_c), .slot_done(sd_c), .frame_done(fd_c));

  // Index of the n-th (0-based) set bit of m.
  function automatic int nth_set(input logic [3:0] m, input int n);
    int c;
    c = 0;
    for (int j = 0; j < 4; j++) begin
      if (m[j]) begin
        if (c == n) return j;
        c++;
      end
    end
    return 0;
  endfunction

  // Expected {e, w, slot_done, frame_done} for cycle i after run is sampled
  // high, with a constant nonzero mask. Each slot occupies div+blank cycles;
  // slots visit the set bits of m in ascending order, repeating every frame.
  function automatic logic [4:0] model(input int div, input int blank,
                                       input logic [3:0] m, input int i);
    int per, s, r, n, pos;
    logic ev, sd, fd;
    logic [1:0] wv;
    per = div + blank;
    s   = i / per;
    r   = i % per;
    n   = $countones(m);
    pos = s % n;
    if (r < div) begin
      ev = 1'b1;
      wv = 2'(nth_set(m, pos));
      sd = (r == div - 1);
      fd = sd && (pos == n - 1);
    end else begin
      ev = 1'b0;
      wv = 2'(nth_set(m, (pos + 1) % n));
      sd = 1'b0;
      fd = 1'b0;
    end
    return {ev, wv, sd, fd};
  endfunction

  // Raise run with mask m, compare len cycles against the model, then drop run
  // and expect every instance idle one cycle later.
  task automatic scan_and_check(input string name, input logic [3:0] m, input int len);
    logic [4:0] exp;
    mask = m;
    run  = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        exp = model(DIVS[d], BLNK[d], m, i);
        n_checks++;
        if (obs[d] !== exp)
          $display("FAIL %s dut%0d cycle %0d mask %b: e/w/sd/fd got %b required %b",
                   name, d, i, m, obs[d], exp);
        else
          n_pass++;
      end
    end
    run = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      n_checks++;
      if (obs[d] !== 5'b0)
        $display("FAIL %s_stop dut%0d: e/w/sd/fd got %b required 00000", name, d, obs[d]);
      else
        n_pass++;
    end
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    run  = 1'b0;
    mask = 4'b0000;
    hold = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      n_checks++;
      if (obs[d] !== 5'b0)
        $display("FAIL reset dut%0d: e/w/sd/fd got %b required 00000", d, obs[d]);
      else
        n_pass++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_scan;
    scan_and_check("full_scan", 4'b1111, 45);
  endtask

  task automatic test_sparse;
    scan_and_check("sparse", 4'b1010, 30);
  endtask

  task automatic test_zero_blank;
    scan_and_check("single_slot", 4'b0001, 12);
  endtask

  // Dropping run after cycle 11 aborts slot 2 of the 4/1 instance on its
  // second active cycle; the restart must begin again at the first slot.
  task automatic test_abort;
    scan_and_check("abort", 4'b1111, 12);
    scan_and_check("restart", 4'b1111, 8);
  endtask

  task automatic test_empty_mask;
    mask = 4'b0000;
    run  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        n_checks++;
        if (obs[d] !== 5'b0)
          $display("FAIL empty_mask dut%0d cycle %0d: e/w/sd/fd got %b required 00000",
                   d, i, obs[d]);
        else
          n_pass++;
      end
    end
    run = 1'b0;
    @(negedge clk);
  endtask

  // Clear mask after the first active cycle: the current slot completes and
  // its slot_done still fires, then the sequencer returns to idle.
  task automatic test_mask_clear;
    logic [4:0] exp;
    mask = 4'b1111;
    run  = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      exp = model(DIVS[d], BLNK[d], 4'b1111, 0);
      n_checks++;
      if (obs[d] !== exp)
        $display("FAIL mask_clear_first dut%0d: e/w/sd/fd got %b required %b", d, obs[d], exp);
      else
        n_pass++;
    end
    mask = 4'b0000;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        exp = (i < DIVS[d]) ? {1'b1, 2'b00, (i == DIVS[d] - 1), 1'b0} : 5'b0;
        n_checks++;
        if (obs[d] !== exp)
          $display("FAIL mask_clear dut%0d cycle %0d: e/w/sd/fd got %b required %b",
                   d, i, obs[d], exp);
        else
          n_pass++;
      end
    end
    run = 1'b0;
    @(negedge clk);
  endtask

  // Assert rst between clock edges: cycle 14 is a blank cycle of the 4/1
  // instance (w=3), cycle 18 is its frame-final active cycle (both pulses high).
  task automatic test_reset_async;
    logic [4:0] exp;
    int stops [2];
    stops = '{14, 18};
    for (int k = 0; k < 2; k++) begin
      mask = 4'b1111;
      run  = 1'b1;
      for (int i = 0; i <= stops[k]; i++) begin
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
          exp = model(DIVS[d], BLNK[d], 4'b1111, i);
          n_checks++;
          if (obs[d] !== exp)
            $display("FAIL pre_reset dut%0d cycle %0d: e/w/sd/fd got %b required %b",
                     d, i, obs[d], exp);
          else
            n_pass++;
        end
      end
      #2 rst = 1'b1;
      #1;
      for (int d = 0; d < NDUT; d++) begin
        n_checks++;
        if (obs[d] !== 5'b0)
          $display("FAIL async_reset dut%0d at cycle %0d: e/w/sd/fd got %b required 00000",
                   d, stops[k], obs[d]);
        else
          n_pass++;
      end
      run = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    logic [3:0] m;
    int len, gap;
    for (int it = 0; it < 16; it++) begin
      m   = 4'($urandom_range(1, 15));
      len = $urandom_range(1, 40);
      scan_and_check("random", m, len);
      mask = 4'($urandom_range(0, 15));
      gap  = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
          n_checks++;
          if (obs[d] !== 5'b0)
            $display("FAIL random_idle dut%0d: e/w/sd/fd got %b required 00000", d, obs[d]);
          else
            n_pass++;
        end
      end
    end
  endtask

`ifdef SCAN_HOLD_EN
  // Hold for three edges on dwell=1 of the 4/1 instance: cycles 2..4 repeat
  // cycle 1, and slot_done moves from cycle 3 to cycle 6.
  task automatic test_hold;
    logic [4:0] exp;
    mask = 4'b1111;
    run  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = (i <= 4) ? 5'b1_00_0_0 : ((i == 6) ? 5'b1_00_1_0 : 5'b1_00_0_0);
      if (i == 7) exp = 5'b0_01_0_0;
      n_checks++;
      if (obs[0] !== exp)
        $display("FAIL hold dut0 cycle %0d: e/w/sd/fd got %b required %b", i, obs[0], exp);
      else
        n_pass++;
      if (i == 1) hold = 1'b1;
      if (i == 4) hold = 1'b0;
    end
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_full_scan();
    test_sparse();
    test_zero_blank();
    test_abort();
    test_empty_mask();
    test_mask_clear();
    test_reset_async();
    test_random();
`ifdef SCAN_HOLD_EN
    test_hold();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
